// File: rtl/defuzz_centroid.sv
// Centroid defuzzifier: accumulates a frame of (mu, x) terms, then divides sum(mu*x) by sum(mu).
// Result is signed Q7.0, truncated toward zero; 0 with out_zero when sum(mu) is 0.
module defuzz_centroid #(
  parameter int MAX_TERMS = 16,
  parameter int GUARD     = $clog2(MAX_TERMS),
  parameter int NUM_W     = 24 + GUARD,
  parameter int DEN_W     = 15 + GUARD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_mu,
  input  logic signed [7:0] in_x,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_y,
  output logic              out_zero,
  output logic              out_ovf
);

  localparam int CNT_W = GUARD + 1;
  localparam int DCW   = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {ACC, DIV, DONE} state_t;

  state_t                   state;
  logic signed [NUM_W-1:0]  num;
  logic [DEN_W-1:0]         den;
  logic [CNT_W-1:0]         cnt;
  logic                     ovf;
  logic                     neg;
  logic [NUM_W-1:0]         dq;
  logic [DEN_W-1:0]         rem;
  logic [DCW-1:0]           div_cnt;

  logic [15:0]              mu_c;
  logic signed [24:0]       prod;
  logic                     cnt_full;
  logic signed [NUM_W-1:0]  num_next;
  logic [DEN_W-1:0]         den_next;
  logic [NUM_W-1:0]         num_mag;
  logic [DEN_W:0]           rem_sh;
  logic                     take;
  logic [DEN_W-1:0]         rem_sub;
  logic [7:0]               q8;
  logic [7:0]               y_fin;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  always_comb begin
    mu_c     = (in_mu > 16'h7FFF) ? 16'h7FFF : in_mu;
    prod     = $signed({1'b0, mu_c}) * in_x;
    cnt_full = (cnt == CNT_W'(MAX_TERMS));
    // Terms beyond MAX_TERMS are handshaken but leave the accumulators untouched
    num_next = cnt_full ? num : num + NUM_W'(prod);
    den_next = cnt_full ? den : den + DEN_W'(mu_c);
    num_mag  = num_next[NUM_W-1] ? NUM_W'(-num_next) : NUM_W'(num_next);

    // One restoring-division step: shift in the next dividend bit, subtract if it fits
    rem_sh   = {rem, dq[NUM_W-1]};
    take     = (rem_sh >= {1'b0, den});
    rem_sub  = DEN_W'(rem_sh - {1'b0, den});

    if (neg) begin
      q8    = (dq > NUM_W'(128)) ? 8'd128 : dq[7:0];
      y_fin = -q8;
    end else begin
      q8    = (dq > NUM_W'(127)) ? 8'd127 : dq[7:0];
      y_fin = q8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      num      <= '0;
      den      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      neg      <= 1'b0;
      dq       <= '0;
      rem      <= '0;
      div_cnt  <= '0;
      out_y    <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            num <= num_next;
            den <= den_next;
            if (cnt_full) ovf <= 1'b1;
            else          cnt <= cnt + CNT_W'(1);
            if (in_last) begin
              if (den_next == '0) begin
                state    <= DONE;
                out_y    <= '0;
                out_zero <= 1'b1;
                out_ovf  <= ovf | cnt_full;
              end else begin
                state   <= DIV;
                dq      <= num_mag;
                rem     <= '0;
                div_cnt <= '0;
                neg     <= num_next[NUM_W-1];
              end
            end
          end
        end
        DIV: begin
          // NUM_W shift cycles followed by one cycle to sign and clamp the quotient
          if (div_cnt == DCW'(NUM_W)) begin
            state    <= DONE;
            out_y    <= y_fin;
            out_zero <= 1'b0;
            out_ovf  <= ovf;
          end else begin
            dq      <= {dq[NUM_W-2:0], take};
            rem     <= take ? rem_sub : rem_sh[DEN_W-1:0];
            div_cnt <= div_cnt + DCW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACC;
            num   <= '0;
            den   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_defuzz_centroid.sv
// Bench for defuzz_centroid: directed frames from the plan plus random frames against an arithmetic model.
module tb_defuzz_centroid;

  localparam int MAX = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_mu = '0;
  logic signed [7:0] in_x = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        out_y;
  logic              out_zero;
  logic              out_ovf;

  int errors = 0;
  int checks = 0;

  logic [15:0]       mu_a [0:31];
  logic signed [7:0] x_a  [0:31];

  defuzz_centroid #(.MAX_TERMS(MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mu(in_mu), .in_x(in_x), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Centroid straight from the definition: first MAX terms count, mu saturates at 0x7FFF.
  task automatic ref_model(input int n, output logic [7:0] y, output bit z, output bit o);
    longint num, den, q, mu;
    num = 0; den = 0;
    for (int i = 0; i < n; i++) begin
      if (i < MAX) begin
        mu  = (mu_a[i] > 16'h7FFF) ? 64'h7FFF : longint'(mu_a[i]);
        num = num + mu * longint'(x_a[i]);
        den = den + mu;
      end
    end
    o = (n > MAX);
    z = (den == 0);
    if (z) q = 0;
    else   q = num / den;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    y = 8'(q);
  endtask

  task automatic send_frame(input int n, input bit gaps);
    int w, g;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1; in_mu = mu_a[i]; in_x = x_a[i]; in_last = (i == n - 1);
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL accept_timeout beat=%0d in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  // Called just after the accepting edge of the last beat; counts further edges until out_valid.
  task automatic wait_result(output int edges, output bit saw_rdy);
    edges = 0; saw_rdy = 1'b0;
    while (!out_valid && edges < 200) begin
      if (in_ready) saw_rdy = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_y !== 8'h00) begin errors++; $display("FAIL reset_out_y got=%h exp=00", out_y); end
    checks++; if ({out_zero, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {out_zero, out_ovf}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    int edges; bit saw;
    logic signed [7:0] ey;
    ey = -8'sd40;
    mu_a[0] = 16'h7FFF; x_a[0] = -8'sd40;
    send_frame(1, 1'b0);
    wait_result(edges, saw);
    checks++; if (edges !== 29) begin errors++; $display("FAIL single_latency got=%0d exp=29", edges); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL single_in_ready_busy got=%b exp=0", saw); end
    checks++; if (out_y !== ey) begin errors++; $display("FAIL single_y got=%0d exp=%0d", $signed(out_y), ey); end
    checks++; if ({out_zero, out_ovf} !== 2'b00) begin errors++; $display("FAIL single_flags got=%b exp=00", {out_zero, out_ovf}); end
    handshake();
  endtask

  task automatic test_two_terms();
    int edges; bit saw;
    mu_a[0] = 16'h4000; x_a[0] = 8'sd10;
    mu_a[1] = 16'h4000; x_a[1] = 8'sd30;
    send_frame(2, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL two_valid got=%b exp=1", out_valid); end
    checks++; if (out_y !== 8'd20) begin errors++; $display("FAIL two_y got=%0d exp=20", $signed(out_y)); end
    handshake();
  endtask

  task automatic test_truncation();
    int edges; bit saw;
    logic signed [7:0] ey;
    mu_a[0] = 16'h2000; x_a[0] = 8'sd0;
    mu_a[1] = 16'h1000; x_a[1] = 8'sd7;
    send_frame(2, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_y !== 8'd2) begin errors++; $display("FAIL trunc_pos_y got=%0d exp=2", $signed(out_y)); end
    handshake();
    x_a[1] = -8'sd7; ey = -8'sd2;
    send_frame(2, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_y !== ey) begin errors++; $display("FAIL trunc_neg_y got=%0d exp=-2", $signed(out_y)); end
    handshake();
    mu_a[0] = 16'hFFFF; x_a[0] = 8'sd5;
    send_frame(1, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_y !== 8'd5) begin errors++; $display("FAIL mu_clamp_y got=%0d exp=5", $signed(out_y)); end
    handshake();
  endtask

  task automatic test_zero_den();
    int edges; bit saw;
    mu_a[0] = 16'h0000; x_a[0] = 8'sd50;
    mu_a[1] = 16'h0000; x_a[1] = -8'sd9;
    send_frame(2, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_latency out_valid=%b exp=1 right after accept", out_valid); end
    wait_result(edges, saw);
    checks++; if (out_y !== 8'h00) begin errors++; $display("FAIL zero_y got=%0d exp=0", $signed(out_y)); end
    checks++; if ({out_zero, out_ovf} !== 2'b10) begin errors++; $display("FAIL zero_flags got=%b exp=10", {out_zero, out_ovf}); end
    handshake();
  endtask

  task automatic test_backpressure();
    int edges; bit saw;
    mu_a[0] = 16'h7FFF; x_a[0] = 8'sd77;
    send_frame(1, 1'b0);
    wait_result(edges, saw);
    // A stray beat offered while busy must not be absorbed
    in_valid = 1'b1; in_mu = 16'h7FFF; in_x = 8'sd100;
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b1 || out_y !== 8'd77 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle=%0d valid=%b y=%0d rdy=%b exp 1/77/0", c, out_valid, $signed(out_y), in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    handshake();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release rdy=%b valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_overflow();
    int edges; bit saw;
    for (int i = 0; i < 17; i++) begin mu_a[i] = 16'h7FFF; x_a[i] = 8'sd10; end
    x_a[16] = -8'sd100;
    send_frame(17, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_y !== 8'd10) begin errors++; $display("FAIL ovf_y got=%0d exp=10", $signed(out_y)); end
    checks++; if ({out_zero, out_ovf} !== 2'b01) begin errors++; $display("FAIL ovf_flags got=%b exp=01", {out_zero, out_ovf}); end
    handshake();
  endtask

  task automatic test_reset_mid_div();
    int edges; bit saw; bit seen;
    mu_a[0] = 16'h7FFF; x_a[0] = -8'sd40;
    send_frame(1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL middiv_valid got=%b exp=0", out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL middiv_ready got=%b exp=1", in_ready); end
    seen = 1'b0;
    repeat (35) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL middiv_stale_result got=%b exp=0", seen); end
    mu_a[0] = 16'h7FFF; x_a[0] = 8'sd5;
    send_frame(1, 1'b0);
    wait_result(edges, saw);
    checks++; if (out_y !== 8'd5 || {out_zero, out_ovf} !== 2'b00) begin
      errors++; $display("FAIL middiv_new_frame y=%0d flags=%b exp 5/00", $signed(out_y), {out_zero, out_ovf});
    end
    handshake();
  endtask

  task automatic test_random();
    int n, mode, r, edges, dly, exp_edges;
    bit saw, ez, eo;
    logic [7:0] ey;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(1, 20);
      mode = $urandom_range(0, 7);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 3);
        if (mode == 0 || r == 0) mu_a[i] = 16'h0000;
        else if (r == 1)         mu_a[i] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
        else                     mu_a[i] = 16'($urandom_range(0, 16'h7FFF));
        x_a[i] = 8'($urandom);
      end
      ref_model(n, ey, ez, eo);
      exp_edges = ez ? 0 : 29;
      send_frame(n, 1'b1);
      wait_result(edges, saw);
      checks++; if (edges !== exp_edges) begin errors++; $display("FAIL rnd_latency frame=%0d got=%0d exp=%0d", f, edges, exp_edges); end
      checks++; if (out_y !== ey || out_zero !== ez || out_ovf !== eo) begin
        errors++; $display("FAIL rnd_result frame=%0d n=%0d y=%0d z=%b o=%b exp y=%0d z=%b o=%b",
                           f, n, $signed(out_y), out_zero, out_ovf, $signed(ey), ez, eo);
      end
      dly = $urandom_range(0, 3);
      repeat (dly) begin @(posedge clk); #1; end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_terms();
    test_truncation();
    test_zero_den();
    test_backpressure();
    test_overflow();
    test_reset_mid_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
